hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports issue_valid (1), issue_rd (5), issue_rd_write (1), issue_is_load (1) and issue_multi_cycle (1), all inputs: decode instruction offered to EX this cycle.
REQ-004 SHALL have ports rs1_index (5), rs2_index (5), rs1_used (1) and rs2_used (1), all inputs: decode source operands.
REQ-005 SHALL have ports ex_done (input, 1), multi-cycle unit result ready, and flush (input, 1), kill the instruction in EX.
REQ-006 SHALL have port stall, output, 1 bit: hold fetch/decode this cycle.
REQ-007 SHALL have ports fwd_sel_1 and fwd_sel_2, outputs, 2 bits: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-008 SHALL have ports busy (output, 1), multi-cycle op in EX, and stall_count (output, 16), saturating count of stalled cycles.

Function
REQ-009 SHALL hold three stage entries (EX, MEM, WB), each {valid, rd, is_load}; valid is set only when rd_write=1 and rd!=0.
REQ-010 SHALL advance entries every cycle when stall=0: EX<-issue (bubble if issue_valid=0), MEM<-EX, WB<-MEM.
REQ-011 SHALL treat register index 0 as never matching any stage.
REQ-012 SHALL compute fwd_sel_N combinationally; match priority is EX, then MEM, then WB, else 00; an unused source gives 00.
REQ-013 SHALL assert stall combinationally (load-use) when EX is valid with is_load=1 and rd equals a used rs; in that case fwd_sel for that source is 00.
REQ-014 SHALL, on a load-use stall, load a bubble into EX while MEM<-EX and WB<-MEM; the stall lasts exactly 1 cycle.
REQ-015 SHALL run an FSM with states IDLE and BUSY, where IDLE->BUSY when an issued instruction has issue_multi_cycle=1 and stall=0.
REQ-016 SHALL, in BUSY, keep busy=1 and stall=1, hold the EX entry, load a bubble into MEM, and let WB<-MEM.
REQ-017 SHALL transition BUSY->IDLE on ex_done=1; stall deasserts in the same cycle as ex_done and the pipeline advances normally.
REQ-018 SHALL ignore ex_done in IDLE.
REQ-019 SHALL, on flush=1, clear EX to a bubble, force the FSM to IDLE, and let MEM/WB advance; flush wins over a simultaneous issue or ex_done.
REQ-020 SHALL increment stall_count on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-021 SHALL, while reset=1, asynchronously clear all entry valids, set the FSM to IDLE, and set stall=0, busy=0, fwd_sel_1=fwd_sel_2=00 and stall_count=0.
REQ-022 SHALL, on reset asserted mid-BUSY or mid-stall, abandon the operation with no residual stall after reset releases.

Structure
REQ-023 SHALL place the stage-entry typedef, the fwd_sel encodings (FWD_RF/FWD_EX/FWD_MEM/FWD_WB) and the FSM state encoding in the shared package hazard_pkg.
REQ-024 SHALL instantiate the sub-module fwd_select once per source operand; it takes the index, used flag and three entries and returns the 2-bit select and a load-hit flag.

Verification
REQ-025 SHALL cover back-to-back ALU ops: issue rd=5, then rs1=5 -> fwd_sel_1=01; the next cycle, rs1=5 -> 10; the next, 11.
REQ-026 SHALL cover load-use: issue load rd=7, then rs2=7 -> stall=1 for 1 cycle, then fwd_sel_2=10 and stall_count=1.
REQ-027 SHALL cover x0: issue rd=0, then rs1=0 -> fwd_sel_1=00 and stall=0.
REQ-028 SHALL cover multi-cycle: issue a div, then ex_done after 4 cycles -> busy=1 and stall=1 for 4 cycles, IDLE on the 5th, and stall_count=4.
REQ-029 SHALL cover flush during BUSY together with ex_done -> EX bubble, busy=0 next cycle, and the flushed rd is never forwarded.
REQ-030 SHALL cover reset asserted mid-BUSY -> all outputs 0 immediately and no stall after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: stage entries,
// forward-select encodings and the multi-cycle FSM states.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } stage_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam stage_t BUBBLE = '0;

  function automatic logic stage_hit(
    input stage_t     e,
    input logic [4:0] idx
  );
    return e.valid && (e.rd == idx) && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward selector: youngest matching stage wins,
// a load still in EX yields a load-use hit instead of a forward.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] index,
  input  logic       used,
  input  stage_t     ex,
  input  stage_t     mem,
  input  stage_t     wb,
  output logic [1:0] sel,
  output logic       load_hit
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic unused_flags;

  assign hit_ex   = used && stage_hit(ex, index);
  assign hit_mem  = used && stage_hit(mem, index);
  assign hit_wb   = used && stage_hit(wb, index);
  assign load_hit = hit_ex && ex.is_load;

  // load data is already in the register path once past EX
  assign unused_flags = mem.is_load ^ wb.is_load;

  always_comb begin
    sel = FWD_RF;
    priority case (1'b1)
      load_hit: sel = FWD_RF;
      hit_ex:   sel = FWD_EX;
      hit_mem:  sel = FWD_MEM;
      hit_wb:   sel = FWD_WB;
      default:  sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks EX/MEM/WB destinations, drives operand
// forwarding, load-use stalls and multi-cycle busy stalls.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_write,
  input  logic        issue_is_load,
  input  logic        issue_multi_cycle,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic        ex_done,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_sel_1,
  output logic [1:0]  fwd_sel_2,
  output logic        busy,
  output logic [15:0] stall_count
);

  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;
  stage_t ex_n;
  stage_t mem_n;
  stage_t wb_n;
  stage_t issue_entry;
  state_t state_q;
  state_t state_n;

  logic load_hit_1;
  logic load_hit_2;
  logic load_use;
  logic busy_stall;

  fwd_select u_fwd_1 (
    .index    (rs1_index),
    .used     (rs1_used),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_sel_1),
    .load_hit (load_hit_1)
  );

  fwd_select u_fwd_2 (
    .index    (rs2_index),
    .used     (rs2_used),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_sel_2),
    .load_hit (load_hit_2)
  );

  assign load_use   = load_hit_1 || load_hit_2;
  assign busy       = (state_q == BUSY);
  assign busy_stall = busy && !ex_done;
  assign stall      = busy_stall || load_use;

  always_comb begin
    issue_entry         = BUBBLE;
    issue_entry.valid   = issue_valid && issue_rd_write
                          && (issue_rd != 5'd0);
    issue_entry.rd      = issue_rd;
    issue_entry.is_load = issue_is_load;
  end

  always_comb begin
    ex_n    = issue_entry;
    mem_n   = ex_q;
    wb_n    = mem_q;
    state_n = state_q;
    if (flush) begin
      // the killed EX op must not reach MEM either
      ex_n    = BUBBLE;
      mem_n   = BUBBLE;
      state_n = IDLE;
    end else if (busy_stall) begin
      ex_n  = ex_q;
      mem_n = BUBBLE;
    end else if (load_use) begin
      ex_n = BUBBLE;
    end else begin
      state_n = (issue_valid && issue_multi_cycle) ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      state_q <= IDLE;
    end else begin
      ex_q    <= ex_n;
      mem_q   <= mem_n;
      wb_q    <= wb_n;
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
